// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: PC / pipeline-register sequencing for load-use stalls,
//   branch squashes, multi-cycle EX holds and HALT drain.
// Latency: event outputs are combinational (Mealy) in RUN; holds/drain are state driven.
// Backpressure: the pipeline is frozen by deasserting pc_en / if_id_en / id_ex_en.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   id_rs/id_rt/id_uses_rt   source operands of the instruction in ID
//   ex_rd/ex_memread     destination and load flag of the instruction in EX
//   ex_branch_taken      taken branch resolved in EX
//   ex_mc_start          one-cycle pulse, multi-cycle op entered EX
//   ex_halt              HALT in EX
//   pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_bubble  pipeline controls
//   halted               pipeline drained after HALT (sticky until rst)
//   stall_count          stall cycle counter
//
// Optional feature: define HAZARD_PERF_CNT_EN to build the saturating stall
// counter; otherwise stall_count is tied to zero.

module pipeline_hazard_ctrl #(
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       id_rs,
    input  logic [2:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic [2:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             ex_branch_taken,
    input  logic             ex_mc_start,
    input  logic             ex_halt,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    // The shared countdown must hold MC_LATENCY-2 and the drain preload of 1.
    localparam int CW = (MC_LATENCY < 2) ? 1 : $clog2(MC_LATENCY);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_BUSY = 2'd1,
        DRAIN   = 2'd2,
        HALTED  = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    logic load_use_hit;
    logic ev_halt;
    logic ev_branch;
    logic ev_mc;
    logic ev_lu;

    // r0 is compared like any other register.
    assign load_use_hit = ex_memread &&
                          ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

    // Priority-encoded RUN events; rst suppresses them so outputs go idle at once.
    always_comb begin
        ev_halt   = 1'b0;
        ev_branch = 1'b0;
        ev_mc     = 1'b0;
        ev_lu     = 1'b0;
        if (!rst && (state == RUN)) begin
            if (ex_halt)
                ev_halt = 1'b1;
            else if (ex_branch_taken)
                ev_branch = 1'b1;
            else if (ex_mc_start)
                ev_mc = 1'b1;
            else if (load_use_hit)
                ev_lu = 1'b1;
        end
    end

    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_en      = 1'b1;
        id_ex_flush   = 1'b0;
        ex_mem_bubble = 1'b0;
        halted        = 1'b0;
        if (!rst) begin
            unique case (state)
                RUN: begin
                    if (ev_halt) begin
                        pc_en       = 1'b0;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (ev_branch) begin
                        // PC still updates so the branch target loads.
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (ev_mc) begin
                        pc_en         = 1'b0;
                        if_id_en      = 1'b0;
                        id_ex_en      = 1'b0;
                        ex_mem_bubble = 1'b1;
                    end else if (ev_lu) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
                MC_BUSY: begin
                    pc_en         = 1'b0;
                    if_id_en      = 1'b0;
                    id_ex_en      = 1'b0;
                    ex_mem_bubble = 1'b1;
                end
                DRAIN: begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end
                HALTED: begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                    halted      = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // cnt counts remaining MC_BUSY cycles or remaining DRAIN cycles (minus one).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (ev_halt) begin
                        state <= DRAIN;
                        cnt   <= CW'(1);
                    end else if (ev_mc && (MC_LATENCY > 1)) begin
                        // The start cycle is the first hold cycle.
                        state <= MC_BUSY;
                        cnt   <= CW'(MC_LATENCY - 2);
                    end
                end
                MC_BUSY: begin
                    if (cnt == '0)
                        state <= RUN;
                    else
                        cnt <= cnt - 1'b1;
                end
                DRAIN: begin
                    if (cnt == '0)
                        state <= HALTED;
                    else
                        cnt <= cnt - 1'b1;
                end
                HALTED: state <= HALTED;
                default: state <= RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;

    // Saturating; the parked HALTED state is not a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_q <= '0;
        else if (!pc_en && (state != HALTED) && (stall_q != {CNT_W{1'b1}}))
            stall_q <= stall_q + 1'b1;
    end

    assign stall_count = stall_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    localparam int L  = 4;
    localparam int CW = 5;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_bubble, halted}
    localparam logic [6:0] O_IDLE   = 7'b1101000;
    localparam logic [6:0] O_LU     = 7'b0001100;
    localparam logic [6:0] O_BR     = 7'b1111100;
    localparam logic [6:0] O_HALT   = 7'b0111100;
    localparam logic [6:0] O_MC     = 7'b0000010;
    localparam logic [6:0] O_DRAIN  = 7'b0001100;
    localparam logic [6:0] O_HALTED = 7'b0001101;

    typedef struct packed {
        logic [2:0] rs;
        logic [2:0] rt;
        logic       uses;
        logic [2:0] rd;
        logic       mr;
        logic       br;
        logic       mc;
        logic       halt;
    } in_t;

    typedef struct {
        in_t        in;
        logic [6:0] exp;
        string      name;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2:0]    id_rs = '0, id_rt = '0, ex_rd = '0;
    logic          id_uses_rt = 1'b0, ex_memread = 1'b0, ex_branch_taken = 1'b0;
    logic          ex_mc_start = 1'b0, ex_halt = 1'b0;
    logic          pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_bubble, halted;
    logic [CW-1:0] stall_count;
    logic [6:0]    got;

    int n_checks = 0;
    int n_fail   = 0;

    pipeline_hazard_ctrl #(.MC_LATENCY(L), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rd(ex_rd), .ex_memread(ex_memread),
        .ex_branch_taken(ex_branch_taken), .ex_mc_start(ex_mc_start), .ex_halt(ex_halt),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_bubble(ex_mem_bubble),
        .halted(halted), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    assign got = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_bubble, halted};

    function automatic in_t mk(int rs, int rt, bit uses, int rd, bit mr, bit br, bit mc, bit halt);
        in_t v;
        v.rs = 3'(rs); v.rt = 3'(rt); v.uses = uses; v.rd = 3'(rd);
        v.mr = mr; v.br = br; v.mc = mc; v.halt = halt;
        return v;
    endfunction

    task automatic apply(input in_t v);
        id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.uses; ex_rd = v.rd;
        ex_memread = v.mr; ex_branch_taken = v.br; ex_mc_start = v.mc; ex_halt = v.halt;
    endtask

    task automatic check_out(input string name, input logic [6:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: outputs got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_cnt(input string name, input int exp_perf);
        logic [CW-1:0] exp;
        exp = PERF ? CW'(exp_perf) : '0;
        n_checks++;
        if (stall_count !== exp) begin
            n_fail++;
            $display("FAIL %s: stall_count got %0d expected %0d at %0t", name, stall_count, exp, $time);
        end
    endtask

    // Drive new inputs just after the edge, sample mid-cycle.
    task automatic step(input in_t v);
        @(posedge clk);
        #1 apply(v);
        #3;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0));
        #3;
        check_out("reset_outputs", O_IDLE);
        check_cnt("reset_count", 0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    vec_t vecs[9];

    // Behavioural reference: remaining hold / drain cycles as plain counts.
    int  mc_left, drain_left, cnt_m;
    bit  halted_m;

    initial begin
        vecs[0] = '{mk(0, 0, 0, 0, 0, 0, 0, 0), O_IDLE, "idle"};
        vecs[1] = '{mk(3, 0, 0, 3, 1, 0, 0, 0), O_LU,   "lu_rs"};
        vecs[2] = '{mk(1, 5, 1, 5, 1, 0, 0, 0), O_LU,   "lu_rt"};
        vecs[3] = '{mk(0, 2, 0, 2, 1, 0, 0, 0), O_IDLE, "rt_unused_no_stall"};
        vecs[4] = '{mk(0, 4, 0, 0, 1, 0, 0, 0), O_LU,   "lu_r0"};
        vecs[5] = '{mk(3, 0, 0, 3, 0, 0, 0, 0), O_IDLE, "no_load"};
        vecs[6] = '{mk(2, 0, 0, 5, 0, 1, 0, 0), O_BR,   "branch"};
        vecs[7] = '{mk(3, 0, 0, 3, 1, 1, 0, 0), O_BR,   "branch_over_lu"};
        vecs[8] = '{mk(4, 6, 1, 7, 1, 0, 0, 0), O_IDLE, "lu_mismatch"};

        // Reset state
        #4;
        check_out("reset_state", O_IDLE);
        check_cnt("reset_state_count", 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single-cycle RUN events
        for (int i = 0; i < 9; i++) begin
            step(vecs[i].in);
            check_out(vecs[i].name, vecs[i].exp);
        end
        step(mk(0, 0, 0, 0, 0, 0, 0, 0));
        check_out("after_table_idle", O_IDLE);
        check_cnt("table_stall_count", 3);

        // Multi-cycle hold: exactly L cycles, inputs ignored while busy
        do_reset();
        step(mk(0, 0, 0, 0, 0, 0, 1, 0)); check_out("mc_hold0", O_MC);
        step(mk(3, 0, 0, 3, 1, 1, 0, 0)); check_out("mc_hold1", O_MC);
        step(mk(0, 0, 0, 0, 0, 0, 0, 1)); check_out("mc_hold2_halt_ignored", O_MC);
        step(mk(0, 0, 0, 0, 0, 0, 1, 0)); check_out("mc_hold3_start_ignored", O_MC);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0)); check_out("mc_release", O_IDLE);
        check_cnt("mc_stall_count", 4);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0)); check_out("mc_stays_idle", O_IDLE);

        // HALT drain then reset
        do_reset();
        step(mk(0, 0, 0, 0, 0, 0, 0, 1)); check_out("halt_cycle", O_HALT);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0)); check_out("drain1", O_DRAIN);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0)); check_out("drain2", O_DRAIN);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0)); check_out("halted", O_HALTED);
        check_cnt("halt_stall_count", 3);
        step(mk(3, 0, 0, 3, 1, 1, 1, 0)); check_out("halted_sticky", O_HALTED);
        check_cnt("halted_no_count", 3);
        @(posedge clk);
        #1 rst = 1'b1;
        #3;
        check_out("halt_reset_outputs", O_IDLE);
        check_cnt("halt_reset_count", 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Reset in the 2nd MC_BUSY cycle abandons the op
        step(mk(0, 0, 0, 0, 0, 0, 1, 0)); check_out("mcr_start", O_MC);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0)); check_out("mcr_busy1", O_MC);
        @(posedge clk);
        #1 rst = 1'b1;
        #3;
        check_out("mcr_reset_idle", O_IDLE);
        check_cnt("mcr_reset_count", 0);
        @(posedge clk);
        #1 rst = 1'b0;
        apply(mk(6, 0, 0, 6, 1, 0, 0, 0));
        #3;
        check_out("mcr_then_lu", O_LU);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0)); check_out("mcr_then_idle", O_IDLE);
        check_cnt("mcr_lu_count", 1);

        // Randomized run against the behavioural model
        do_reset();
        mc_left = 0; drain_left = 0; halted_m = 0; cnt_m = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            in_t        v;
            logic [6:0] exp;
            bit         lu, was_halted;
            @(posedge clk);
            #1;
            v = mk($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0),
                   ($urandom_range(0, 39) == 0));
            apply(v);
            rst = ($urandom_range(0, 49) == 0);
            #3;
            if (rst) begin
                mc_left = 0; drain_left = 0; halted_m = 0; cnt_m = 0;
                check_out("rand_reset", O_IDLE);
                check_cnt("rand_reset_count", 0);
                continue;
            end
            was_halted = halted_m;
            lu = v.mr && ((v.rd == v.rs) || (v.uses && (v.rd == v.rt)));
            if (halted_m) begin
                exp = O_HALTED;
            end else if (drain_left > 0) begin
                exp = O_DRAIN;
                drain_left--;
                if (drain_left == 0) halted_m = 1;
            end else if (mc_left > 0) begin
                exp = O_MC;
                mc_left--;
            end else if (v.halt) begin
                exp = O_HALT;
                drain_left = 2;
            end else if (v.br) begin
                exp = O_BR;
            end else if (v.mc) begin
                exp = O_MC;
                mc_left = L - 1;
            end else if (lu) begin
                exp = O_LU;
            end else begin
                exp = O_IDLE;
            end
            check_out("rand_outputs", exp);
            check_cnt("rand_count", cnt_m);
            if (!exp[6] && !was_halted && cnt_m < (1 << CW) - 1) cnt_m++;
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Pipeline sequencing controller for the 19-bit CPU. Sits beside the forwarding unit and covers the hazards forwarding cannot resolve: load-use stalls, branch squashes, multi-cycle EX operations and HALT drain. Drives the PC and pipeline-register enable/flush controls every cycle.

## Interface
Parameters:
- MC_LATENCY, 4, number of cycles the pipeline is held for a multi-cycle EX op (≥1)
- CNT_W, 16, width of the stall performance counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- id_rs  in  3  source register 1 of the instruction in ID
- id_rt  in  3  source register 2 of the instruction in ID
- id_uses_rt  in  1  ID instruction reads id_rt
- ex_rd  in  3  destination register of the instruction in EX
- ex_memread  in  1  EX instruction is a load
- ex_branch_taken  in  1  EX resolved a taken branch/jump this cycle
- ex_mc_start  in  1  one-cycle pulse: a multi-cycle op entered EX
- ex_halt  in  1  EX instruction is HALT
- pc_en  out  1  PC update enable
- if_id_en  out  1  IF/ID register load enable
- if_id_flush  out  1  IF/ID register cleared to NOP
- id_ex_en  out  1  ID/EX register load enable
- id_ex_flush  out  1  ID/EX register cleared to NOP
- ex_mem_bubble  out  1  EX/MEM loads a NOP instead of the EX result
- halted  out  1  pipeline drained after HALT
- stall_count  out  CNT_W  stall cycle counter

## Operation
- States: RUN, MC_BUSY, DRAIN, HALTED. Reset state RUN.
- Idle outputs (RUN, no event): pc_en=1, if_id_en=1, id_ex_en=1, all flushes/bubble 0, halted=0.
- Events in RUN, decided combinationally (Mealy), priority halt > branch > mc > load-use:
  - ex_halt: pc_en=0, if_id_flush=1, id_ex_flush=1; go DRAIN, drain counter=1.
  - ex_branch_taken: pc_en=1 (target loads), if_id_flush=1, id_ex_flush=1; stay RUN.
  - ex_mc_start: hold = pc_en=0, if_id_en=0, id_ex_en=0, ex_mem_bubble=1; if MC_LATENCY==1 stay RUN, else go MC_BUSY with cnt=MC_LATENCY-2.
  - load-use: ex_memread && (ex_rd==id_rs || (id_uses_rt && ex_rd==id_rt)); pc_en=0, if_id_en=0, id_ex_flush=1 for that cycle; stay RUN. All 8 registers compared, r0 included.
- MC_BUSY: hold outputs; if cnt==0 go RUN else cnt−1. All event inputs ignored.
- DRAIN: pc_en=0, if_id_en=0, id_ex_flush=1; after 2 DRAIN cycles go HALTED.
- HALTED: DRAIN outputs plus halted=1; sticky until rst.

## Timing
- Load-use bubble: exactly 1 cycle; the load leaves EX the next cycle, clearing the condition.
- Multi-cycle hold: exactly MC_LATENCY consecutive cycles starting with the ex_mc_start cycle; op leaves EX on the following cycle.
- Branch: 1-cycle squash, no stall.
- HALT: halted rises 3 cycles after the ex_halt cycle (1 RUN + 2 DRAIN).
- rst asserted: state → RUN, counters → 0 immediately, Mealy event terms suppressed, outputs at idle values; mid-MC_BUSY or DRAIN reset abandons the operation.
- ex_mc_start pulse while not in RUN: ignored.

## Configuration
- HAZARD_PERF_CNT_EN defined: stall_count increments by 1 every cycle pc_en==0 and state≠HALTED, saturates at 2^CNT_W−1, cleared by rst.
- Undefined: no counter register; stall_count tied to 0.

## Test plan
- Load-use: ex_memread=1, ex_rd=3, id_rs=3 -> one cycle pc_en=0, if_id_en=0, id_ex_flush=1; next cycle (ex_memread=0) idle outputs.
- No false stall: ex_memread=1, ex_rd=2, id_rs=0, id_rt=2, id_uses_rt=0 -> idle outputs.
- MC_LATENCY=4, ex_mc_start pulse -> pc_en=0, id_ex_en=0, ex_mem_bubble=1 for exactly 4 cycles, then idle; stall_count=4 with macro.
- Branch plus load-use same cycle -> pc_en=1, if_id_flush=1, id_ex_flush=1; no stall cycle.
- ex_halt pulse -> halted=1 from 3rd cycle after, pc_en=0 held; rst then -> RUN, halted=0, stall_count=0.
- rst asserted in 2nd MC_BUSY cycle -> outputs idle immediately; subsequent load-use handled normally.
